// File: rtl/pixel_stream_decoder_if.sv
// Word-in / pixel-out stream bundle plus palette write port for pixel_stream_decoder.
// The master side feeds words and palette writes and consumes pixels.
interface pixel_stream_decoder_if #(
   parameter int unsigned PIX_PER_WORD = 2,
   parameter int unsigned CODE_W       = 8,
   parameter int unsigned RGB_W        = 24
);
   logic                             IN_VALID;
   logic                             IN_READY;
   logic [PIX_PER_WORD*CODE_W-1:0]   IN_WORD;
   logic                             PIX_VALID;
   logic                             PIX_READY;
   logic [RGB_W-1:0]                 PIX_RGB;
   logic                             PIX_LAST;
   logic                             PAL_WE;
   logic [CODE_W-1:0]                PAL_ADDR;
   logic [RGB_W-1:0]                 PAL_DATA;

   modport master (
      output IN_VALID, IN_WORD, PIX_READY, PAL_WE, PAL_ADDR, PAL_DATA,
      input  IN_READY, PIX_VALID, PIX_RGB, PIX_LAST
   );

   modport slave (
      input  IN_VALID, IN_WORD, PIX_READY, PAL_WE, PAL_ADDR, PAL_DATA,
      output IN_READY, PIX_VALID, PIX_RGB, PIX_LAST
   );
endinterface

// File: rtl/pixel_stream_decoder.sv
// Unpacks words of palette codes and emits one palette-mapped RGB pixel per clock
// on a valid/ready stream, with a run-time writable palette.
module pixel_stream_decoder #(
   parameter int unsigned PIX_PER_WORD = 2,
   parameter int unsigned CODE_W       = 8,
   parameter int unsigned RGB_W        = 24
) (
   input logic                   CLK,
   input logic                   RESET_N,
   pixel_stream_decoder_if.slave bus
);

   localparam int unsigned CNT_W     = $clog2(PIX_PER_WORD) + 1;
   localparam int unsigned WORD_W    = PIX_PER_WORD * CODE_W;
   localparam int unsigned PAL_DEPTH = 2 ** CODE_W;

   logic [RGB_W-1:0]  palette [PAL_DEPTH];

   logic [WORD_W-1:0] word_buf, word_buf_nx;
   logic [CNT_W-1:0]  rem, rem_nx;
   logic [CNT_W-1:0]  idx, idx_nx;
   logic              pix_valid, pix_valid_nx;
   logic              pix_last, pix_last_nx;
   logic [RGB_W-1:0]  pix_rgb, pix_rgb_nx;

   logic [CODE_W-1:0] code_first;
   logic [CODE_W-1:0] code_cur;
   logic              adv;
   logic              in_ready;
   logic              accept;

   assign adv        = !pix_valid || bus.PIX_READY;
   assign in_ready   = RESET_N && (rem == '0) && adv;
   assign accept     = bus.IN_VALID && in_ready;
   assign code_first = bus.IN_WORD[WORD_W-1 -: CODE_W];

   // Code idx of the buffered word, counting from the most significant slot.
   always_comb begin
      code_cur = '0;
      for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
         if (idx == CNT_W'(k)) begin
            code_cur = word_buf[(PIX_PER_WORD-k)*CODE_W-1 -: CODE_W];
         end
      end
   end

   always_comb begin
      word_buf_nx  = word_buf;
      rem_nx       = rem;
      idx_nx       = idx;
      pix_valid_nx = pix_valid;
      pix_last_nx  = pix_last;
      pix_rgb_nx   = pix_rgb;
      if (accept) begin
         pix_rgb_nx   = palette[code_first];
         pix_valid_nx = 1'b1;
         pix_last_nx  = (PIX_PER_WORD == 1);
         word_buf_nx  = bus.IN_WORD;
         rem_nx       = CNT_W'(PIX_PER_WORD - 1);
         idx_nx       = CNT_W'(1);
      end else if ((rem != '0) && adv) begin
         pix_rgb_nx   = palette[code_cur];
         pix_valid_nx = 1'b1;
         pix_last_nx  = (rem == CNT_W'(1));
         rem_nx       = rem - CNT_W'(1);
         idx_nx       = idx + CNT_W'(1);
      end else if (adv) begin
         // Colour and last flag hold their previous values when the stream goes idle.
         pix_valid_nx = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         word_buf  <= '0;
         rem       <= '0;
         idx       <= '0;
         pix_valid <= 1'b0;
         pix_last  <= 1'b0;
         pix_rgb   <= '0;
      end else begin
         word_buf  <= word_buf_nx;
         rem       <= rem_nx;
         idx       <= idx_nx;
         pix_valid <= pix_valid_nx;
         pix_last  <= pix_last_nx;
         pix_rgb   <= pix_rgb_nx;
      end
   end

   // Lookups read the stored array, so a same-edge write is only seen next cycle.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         for (int unsigned a = 0; a < PAL_DEPTH; a++) begin
            palette[a] <= '0;
         end
      end else if (bus.PAL_WE) begin
         palette[bus.PAL_ADDR] <= bus.PAL_DATA;
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.PIX_VALID = pix_valid;
   assign bus.PIX_RGB   = pix_rgb;
   assign bus.PIX_LAST  = pix_last;

endmodule
